// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types, constants and helpers for the 4:1 TDM link
package tdm_pkg;
   typedef enum logic {HUNT, SYNC} state_t;
   localparam int TDM_LANES = 4;
   function automatic int sel_width(input int lanes);
      for (int w = 1; w < 32; w++)
         if ((1 << w) >= lanes) return w;
      return 32;
   endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index counter with enable, load-to-1, clear and wrap at LANES-1
module tdm_slot_counter #(
   parameter int LANES = 4,
   parameter int SELW  = 2
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            en_i,
   input  logic            load1_i,
   input  logic            clr_i,
   output logic [SELW-1:0] cnt_o
);
   logic [SELW-1:0] cnt_q, cnt_d;
   // clear beats load beats increment; increment wraps after the last slot
   always_comb
      cnt_d = clr_i   ? '0 :
              load1_i ? SELW'(1) :
              en_i    ? ((cnt_q == SELW'(LANES - 1)) ? '0 : cnt_q + SELW'(1)) :
                        cnt_q;
   // counter register
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: TDM receiver rebuilding the parallel word from the serial slot stream
module tdm_demux4 import tdm_pkg::*; #(
   parameter int LANES = TDM_LANES,
   parameter int SELW  = sel_width(LANES)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             DIN,
   input  logic             DIN_VALID,
   input  logic             FSYNC,
   output logic [LANES-1:0] OUT,
   output logic             OUT_VALID,
   output logic [SELW-1:0]  SEL,
   output logic             LOCKED,
   output logic             SYNC_ERR
);
   state_t           state_q, state_d;
   logic [LANES-1:0] word_q, word_d, out_q, out_d;
   logic             out_valid_q, out_valid_d, sync_err_q, sync_err_d;
   logic             cnt_en, cnt_load1, cnt_clr;

   tdm_slot_counter #(.LANES(LANES), .SELW(SELW)) u_cnt (
      .clk_i   (CLK),
      .rst_n_i (RST_N),
      .en_i    (cnt_en),
      .load1_i (cnt_load1),
      .clr_i   (cnt_clr),
      .cnt_o   (SEL)
   );

   // framing FSM: slot 0 always restarts the word so OUT only ever holds bits of one frame
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      sync_err_d  = 1'b0;
      cnt_en      = 1'b0;
      cnt_load1   = 1'b0;
      cnt_clr     = 1'b0;
      if (DIN_VALID) begin
         if (FSYNC) begin
            sync_err_d = (state_q == SYNC) && (SEL != '0);
            word_d     = {{(LANES-1){1'b0}}, DIN};
            cnt_load1  = 1'b1;
            state_d    = SYNC;
         end else if (state_q == SYNC && SEL == '0) begin
            sync_err_d = 1'b1;
            cnt_clr    = 1'b1;
            state_d    = HUNT;
         end else if (state_q == SYNC) begin
            word_d[SEL] = DIN;
            cnt_en      = 1'b1;
            if (SEL == SELW'(LANES - 1)) begin
               out_d       = word_d;
               out_valid_d = 1'b1;
            end
         end
      end
   end

   // state, partial word and registered outputs
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         state_q     <= HUNT;
         word_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         sync_err_q  <= sync_err_d;
      end

   assign OUT       = out_q;
   assign OUT_VALID = out_valid_q;
   assign SYNC_ERR  = sync_err_q;
   assign LOCKED    = (state_q == SYNC);
endmodule
